// File: rtl/sap1_control_unit_pkg.sv
// sap1_pkg: opcodes, ALU selects, sequencer states and control word shared across the SAP-1 design
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_PASS = 3'b111;

    typedef enum logic [2:0] {S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_t;

    typedef struct packed {
        logic       pc_inc;
        logic       pc_out;
        logic       mar_load;
        logic       mem_rd;
        logic       ir_load;
        logic       ir_out;
        logic       a_load;
        logic       a_out;
        logic       b_load;
        logic       alu_out;
        logic [2:0] alu_op;
        logic       out_load;
    } ctrl_t;

    // Maps an ALU-class opcode to the ALU select; anything else passes A through
    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        return op == OP_ADD ? ALU_ADD :
               op == OP_SUB ? ALU_SUB :
               op == OP_AND ? ALU_AND :
               op == OP_OR  ? ALU_OR  :
               op == OP_XOR ? ALU_XOR : ALU_PASS;
    endfunction

endpackage

// File: rtl/sap1_control_unit_if.sv
// sap1_control_unit_if: run/opcode inputs and datapath control lines of the sequencer
interface sap1_control_unit_if;
    logic       run;
    logic [3:0] ir_opcode;
    logic       pc_inc;
    logic       pc_out;
    logic       mar_load;
    logic       mem_rd;
    logic       ir_load;
    logic       ir_out;
    logic       a_load;
    logic       a_out;
    logic       b_load;
    logic       alu_out;
    logic [2:0] alu_op;
    logic       out_load;
    logic       halted;
    logic [5:0] t_state;

    modport master (
        input  run, ir_opcode,
        output pc_inc, pc_out, mar_load, mem_rd, ir_load, ir_out, a_load, a_out,
               b_load, alu_out, alu_op, out_load, halted, t_state
    );

    modport slave (
        output run, ir_opcode,
        input  pc_inc, pc_out, mar_load, mem_rd, ir_load, ir_out, a_load, a_out,
               b_load, alu_out, alu_op, out_load, halted, t_state
    );
endinterface

// File: rtl/sap1_control_unit_ring_counter.sv
// sap1_ring_counter: six-phase T1-T6 sequencer with run hold and absorbing HALT
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       hlt,
    output state_t     state,
    output logic [5:0] t_state
);

    // Advance one phase per enabled cycle; HLT leaves T4 for HALT, which only reset exits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_T1;
            t_state <= 6'b000001;
        end else if (run) begin
            case (state)
                S_T1: begin state <= S_T2; t_state <= 6'b000010; end
                S_T2: begin state <= S_T3; t_state <= 6'b000100; end
                S_T3: begin state <= S_T4; t_state <= 6'b001000; end
                S_T4: begin
                    state   <= hlt ? S_HALT : S_T5;
                    t_state <= hlt ? 6'b000000 : 6'b010000;
                end
                S_T5: begin state <= S_T6; t_state <= 6'b100000; end
                S_T6: begin state <= S_T1; t_state <= 6'b000001; end
                default: begin state <= S_HALT; t_state <= 6'b000000; end
            endcase
        end
    end

endmodule

// File: rtl/sap1_control_unit.sv
// sap1_control_unit: decodes sequencer phase and IR opcode into SAP-1 datapath controls
module sap1_control_unit
    import sap1_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    sap1_control_unit_if.master bus
);

    state_t state;
    ctrl_t  c;
    logic   is_lda, is_alu, is_out;

    assign is_lda = bus.ir_opcode == OP_LDA;
    assign is_alu = bus.ir_opcode >= OP_ADD && bus.ir_opcode <= OP_XOR;
    assign is_out = bus.ir_opcode == OP_OUT;

    sap1_ring_counter u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (bus.run),
        .hlt     (bus.ir_opcode == OP_HLT),
        .state   (state),
        .t_state (bus.t_state)
    );

    // Control word per phase; opcode only consulted in T4-T6, everything quiet when stopped or in reset
    always_comb begin
        c        = '0;
        c.alu_op = ALU_PASS;
        if (bus.run && rst_n) begin
            case (state)
                S_T1: begin c.pc_out = 1'b1; c.mar_load = 1'b1; end
                S_T2: c.pc_inc = 1'b1;
                S_T3: begin c.mem_rd = 1'b1; c.ir_load = 1'b1; end
                S_T4: begin
                    c.ir_out   = is_lda | is_alu;
                    c.mar_load = is_lda | is_alu;
                    c.a_out    = is_out;
                    c.out_load = is_out;
                end
                S_T5: begin
                    c.mem_rd = is_lda | is_alu;
                    c.a_load = is_lda;
                    c.b_load = is_alu;
                end
                S_T6: begin
                    c.alu_out = is_alu;
                    c.a_load  = is_alu;
                    c.alu_op  = is_alu ? alu_sel(bus.ir_opcode) : ALU_PASS;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_inc   = c.pc_inc;
    assign bus.pc_out   = c.pc_out;
    assign bus.mar_load = c.mar_load;
    assign bus.mem_rd   = c.mem_rd;
    assign bus.ir_load  = c.ir_load;
    assign bus.ir_out   = c.ir_out;
    assign bus.a_load   = c.a_load;
    assign bus.a_out    = c.a_out;
    assign bus.b_load   = c.b_load;
    assign bus.alu_out  = c.alu_out;
    assign bus.alu_op   = c.alu_op;
    assign bus.out_load = c.out_load;
    assign bus.halted   = state == S_HALT;

endmodule

// File: tb/tb_sap1_control_unit.sv
// tb_sap1_control_unit: scoreboard bench for the SAP-1 control unit
module tb_sap1_control_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sap1_control_unit_if bus();
    sap1_control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_pass = 0;
    int n_chk = 0;
    int ph = 0;
    logic [20:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Expected {pc_inc,pc_out,mar_load,mem_rd,ir_load,ir_out,a_load,a_out,b_load,alu_out,alu_op,out_load,halted,t_state}
    function automatic logic [20:0] model(input int p, input logic [3:0] op, input logic r, input logic rn);
        logic [9:0] f;
        logic [2:0] a;
        logic o, h, lda, alu, outi;
        logic [5:0] t;
        lda = op == 4'd0;
        alu = op >= 4'd1 && op <= 4'd5;
        outi = op == 4'd14;
        f = '0;
        a = 3'b111;
        o = 1'b0;
        h = rn && p == 6;
        t = !rn ? 6'b000001 : (p == 6 ? 6'b000000 : 6'(1 << p));
        if (rn && r && p != 6) begin
            if (p == 0) f = 10'b0110000000;
            if (p == 1) f = 10'b1000000000;
            if (p == 2) f = 10'b0001100000;
            if (p == 3 && (lda || alu)) f = 10'b0010010000;
            if (p == 3 && outi) begin f = 10'b0000000100; o = 1'b1; end
            if (p == 4 && lda) f = 10'b0001001000;
            if (p == 4 && alu) f = 10'b0001000010;
            if (p == 5 && alu) begin f = 10'b0000001001; a = 3'(op - 4'd1); end
        end
        return {f, a, o, h, t};
    endfunction

    function automatic logic [20:0] obs();
        return {bus.pc_inc, bus.pc_out, bus.mar_load, bus.mem_rd, bus.ir_load, bus.ir_out,
                bus.a_load, bus.a_out, bus.b_load, bus.alu_out, bus.alu_op, bus.out_load,
                bus.halted, bus.t_state};
    endfunction

    task automatic step(input logic r, input logic [3:0] op, input string tag, input bit adv = 1'b1);
        int nd;
        bus.run = r;
        bus.ir_opcode = op;
        #1;
        sb.push_back(model(ph, op, r, rst_n));
        check(tag, 32'(obs()), 32'(sb.pop_front()));
        nd = int'(bus.pc_out) + int'(bus.mem_rd) + int'(bus.ir_out) + int'(bus.a_out) + int'(bus.alu_out);
        check({tag, "_drv"}, 32'(nd <= 1), 32'd1);
        if (r && rst_n) ph = ph == 6 ? 6 : ph == 5 ? 0 : (ph == 3 && op == 4'd15) ? 6 : ph + 1;
        if (adv) @(negedge clk);
    endtask

    task automatic run_instr(input logic [3:0] op, input string tag);
        for (int i = 0; i < 6; i++) step(1'b1, i < 3 ? 4'($urandom) : op, tag);
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        step(1'b1, 4'd15, tag);
        ph = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.run = 1'b0;
        bus.ir_opcode = 4'd0;
        @(negedge clk);
        step(1'b1, 4'd0, "reset");
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) step(1'b1, 4'd0, "lda");
        reset_pulse("rst_a");
        run_instr(4'd2, "sub");
        step(1'b1, 4'd1, "add_t1");
        step(1'b1, 4'd1, "add_t2");
        for (int i = 0; i < 4; i++) step(1'b0, 4'($urandom), "add_hold");
        for (int i = 0; i < 4; i++) step(1'b1, 4'd1, "add_resume");
        for (int i = 0; i < 4; i++) step(1'b1, 4'd15, "hlt");
        for (int i = 0; i < 20; i++) step(1'b1, 4'($urandom), "halt");
        reset_pulse("halt_rst");
        for (int i = 0; i < 4; i++) step(1'b1, 4'd5, "xor");
        step(1'b1, 4'd5, "xor_t5", 1'b0);
        #2 rst_n = 1'b0;
        #1;
        sb.push_back(model(0, 4'd5, 1'b1, rst_n));
        check("async_rst", 32'(obs()), 32'(sb.pop_front()));
        ph = 0;
        @(negedge clk);
        step(1'b1, 4'd5, "rst_hold");
        rst_n = 1'b1;
        step(1'b1, 4'd5, "after_rst");
        reset_pulse("rst_b");
        for (int op = 0; op < 16; op++) run_instr(4'(op), $sformatf("sweep_%0d", op));
        step(1'b1, 4'd0, "sweep_end");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sap1_control_unit.md
# sap1_control_unit

Instruction sequencer for the SAP-1 datapath. It steps a six-phase ring counter through fetch and execute. It decodes the 4-bit opcode held in the instruction register and drives every datapath control line each cycle, including the 3-bit operation select of the 8-bit ALU. It sits between the instruction register and the bus-attached registers (PC, MAR, RAM, IR, A, B, OUT). It owns the only run/halt state in the design.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level enable; 0 freezes the sequencer
- ir_opcode  in  4  upper nibble of the IR; valid from T4 onward
- pc_inc  out  1  increment PC
- pc_out  out  1  PC drives bus
- mar_load  out  1  MAR loads from bus
- mem_rd  out  1  RAM drives bus
- ir_load  out  1  IR loads from bus
- ir_out  out  1  IR lower nibble drives bus
- a_load  out  1  A loads from bus
- a_out  out  1  A drives bus
- b_load  out  1  B loads from bus
- alu_out  out  1  ALU result drives bus
- alu_op  out  3  ALU select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 111 pass A
- out_load  out  1  output register loads from bus
- halted  out  1  sticky halt flag
- t_state  out  6  one-hot phase, bit0 = T1; all zero in HALT

## Operation
Opcodes:
- 0000 LDA
- 0001 ADD
- 0010 SUB
- 0011 AND
- 0100 OR
- 0101 XOR
- 1110 OUT
- 1111 HLT
- all others NOP

The state register has seven states: T1–T6, then HALT.

Fetch phases, identical for every instruction:
- T1: pc_out, mar_load
- T2: pc_inc
- T3: mem_rd, ir_load

Execute phases by instruction:
- LDA: T4 ir_out, mar_load; T5 mem_rd, a_load; T6 idle
- ALU ops: T4 ir_out, mar_load; T5 mem_rd, b_load; T6 alu_out, a_load, alu_op = mapped code
- OUT: T4 a_out, out_load; T5 and T6 idle
- NOP: T4–T6 idle
- HLT: T4 asserts nothing; next state is HALT

Rules:
- At most one bus driver is asserted in any state: pc_out, mem_rd, ir_out, a_out or alu_out.
- alu_op = 111 in every state except T6 of an ALU op.
- Every instruction takes exactly 6 cycles; T6 returns to T1.
- HALT is absorbing. All controls are 0, halted = 1, and only rst_n exits it.
- run = 0 holds the state and forces all control outputs to 0 (alu_op = 111). t_state still shows the held phase. Resuming continues from the held phase.

## Timing
- Control outputs are combinational decodes of the state register and ir_opcode. The datapath acts on them at the next rising edge, so one phase equals one cycle.
- ir_opcode is sampled only in T4–T6. Its value in T1–T3 must not affect any output.
- Reset (asynchronous, at any point including mid-instruction or HALT):
  - state = T1, halted = 0
  - while rst_n = 0, all control outputs = 0, alu_op = 111, t_state = 000001
- First edge after rst_n deasserts with run = 1: executes T1.
- HLT: T4 of the HLT instruction is cycle 4. HALT is entered at the edge ending T4; halted rises in cycle 5 and t_state = 0.
- run falling in the middle of a phase: that phase's actions are suppressed at that edge and are issued again once run returns.

## Structure
- Package sap1_pkg holds:
  - opcode localparams
  - ALU op codes, shared with the ALU
  - state encoding
  - a typedef for the control-word struct
- One sub-module, sap1_ring_counter. It contains the T1–T6/HALT state register with run hold, halt entry and asynchronous reset, and outputs the state and t_state. The top level holds the decode logic.

## Test plan
- Reset, then run = 1 for 6 cycles with ir_opcode = 0000 → t_state sequence 01, 02, 04, 08, 10, 20, then back to 01. T5 shows mem_rd = a_load = 1.
- ir_opcode = 0010 (SUB) → T5: b_load = 1. T6: alu_out = a_load = 1, alu_op = 001. Every other cycle: alu_op = 111.
- ir_opcode = 1111 → halted = 1 in cycle 5 and stays 1 for 20 further cycles with all controls 0. Pulsing rst_n low returns t_state = 01 and halted = 0.
- run = 0 during T3 of ADD for 4 cycles → t_state held at 04 with ir_load = 0. After run = 1, ir_load = 1 for one cycle, then T4.
- rst_n asserted asynchronously mid-T5 of XOR → outputs go to 0 without waiting for a clock edge. After release, the first phase is T1.
- Sweep all 16 opcodes, checking every cycle → at most one bus driver asserted. Opcodes 0110–1101 produce no activity in T4–T6.
